utf_stream_encoder: RTL and testbench
=====================================

// Module: utf_stream_encoder
// PURPOSE
//  Streaming transmitter: accepts one Unicode code point per valid/ready handshake and serialises it into
//  a UTF-8, UTF-16LE or UTF-16BE byte stream on a second valid/ready port. It pairs with
//  hardware_utf8, which takes bytes in; this block drives bytes out from scalar code points.
//  It sits between a code-point producer and a byte sink such as a UART or FIFO.
// PARAMETERS
//  REPLACE_INVALID  1  1: an invalid code point emits the U+FFFD encoding; 0: it is dropped (no bytes out)
//  CHK_RANGE        1  1: cp > 0x10FFFF is invalid; 0: UTF-8 may emit 5/6-byte forms up to 0x7FFFFFFF
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   reset, asynchronous, active-low
//  mode         in   2   00 UTF-8, 01 UTF-16LE, 10 UTF-16BE, 11 reserved (treated as UTF-8); sampled on accept
//  cp_valid     in   1   code point offered
//  cp_ready     out  1   code point accepted when cp_valid & cp_ready
//  cp           in   32  code point
//  byte_valid   out  1   byte_data valid
//  byte_ready   in   1   sink consumes the byte when byte_valid & byte_ready
//  byte_data    out  8   output byte
//  byte_last    out  1   byte_data is the final byte of the current character
//  err_invalid  out  1   one-cycle pulse in the cycle after an invalid cp is accepted
//  err_count    out  16  count of invalid code points, saturates at 0xFFFF
//  busy         out  1   a character is being emitted (state EMIT)
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; byte_valid, byte_data, byte_last, err_invalid, err_count, busy = 0;
//   cp_ready is forced to 0 while rst=0.
//  States
//   IDLE: cp_ready=1. On accept, latch the encoded bytes and length, then go to EMIT. Dropped invalid cp: stay IDLE.
//   EMIT: byte_valid=1. On each handshake, advance the byte index. On the handshake of the last byte:
//    return to IDLE, or take a new cp in the same cycle (see back-to-back).
//  cp_ready = ~rst_low & (IDLE | (EMIT & byte_ready & byte_last)) -- combinational, zero-bubble.
//  Latency: the first byte appears on byte_valid in the cycle after accept. With byte_ready held at 1,
//   one byte is emitted per cycle and there are no gaps between characters.
//  Backpressure: while byte_valid & ~byte_ready, byte_data and byte_last hold stable; no byte is ever skipped.
//  Validity: invalid if cp[31]=1, or 0xD800<=cp<=0xDFFF, or (cp>0x10FFFF and (CHK_RANGE | mode is UTF-16)).
//  UTF-8 length: <0x80 ->1, <0x800 ->2, <0x10000 ->3, <0x200000 ->4, <0x4000000 ->5, else 6.
//   Lead byte is 0xxxxxxx/110/1110/11110/111110/1111110, followed by 10xxxxxx continuation bytes, MS bits first.
//  UTF-16: cp<0x10000 gives 2 bytes. Otherwise cp'=cp-0x10000, hs=0xD800|cp'[19:10], ls=0xDC00|cp'[9:0]
//   (4 bytes). LE sends the low byte of each unit first; BE sends the high byte first.
//  Replacement: UTF-8 EF BF BD; UTF-16LE FD FF; UTF-16BE FF FD. err_invalid pulses either way.
//  err_count increments by 1 per invalid accept and holds at 0xFFFF.
//  mode changes mid-character have no effect until the next accept.
//  Asserting rst mid-character aborts it immediately. Untransmitted bytes are lost; there is no partial replay.
//  cp_valid low in IDLE: nothing happens; outputs hold their reset or idle values.
// STRUCTURE
//  Package utf_pkg: mode constants (UTF8, UTF16LE, UTF16BE); U+FFFD; CP_MAX=0x10FFFF;
//   SURR_LO=0xD800, SURR_HI=0xDFFF; function utf8_len(cp).
//  Sub-module utf_cp_encode (combinational): cp, mode, CHK_RANGE -> invalid, len[2:0], bytes[6][8].
//   The top level holds the FSM, byte buffer, index counter, handshake and error counter.
// TESTING
//  cp=0x41, UTF-8, byte_ready=1 -> one byte 41, byte_last=1, next cycle cp_ready=1.
//  cp=0x1F600: UTF-8 -> F0 9F 98 80; UTF-16LE -> 3D D8 00 DE; UTF-16BE -> D8 3D DE 00; last set on the 4th byte.
//  cp=0x20AC then 0x41 back-to-back, byte_ready=1 -> E2 82 AC 41 in 4 consecutive cycles, no gap.
//  byte_ready low for 3 cycles after the 2nd byte of 0x20AC -> byte_data stays 82 and cp_ready stays 0.
//  cp=0xD800, REPLACE_INVALID=1 -> EF BF BD, err_invalid 1-cycle pulse, err_count=1;
//   with REPLACE_INVALID=0 -> no bytes out, err_count=1.
//  cp=0x110000: CHK_RANGE=0, UTF-8 -> F4 90 80 80; then rst pulsed mid-sequence -> byte_valid=0 at once, err_count=0.

Source files
------------

// File: rtl/utf_pkg.sv
// rtl/utf_pkg.sv - shared constants, state type and helpers for the UTF stream encoder
// Contents: mode codes, code-point limits, FSM state enum, byte vector type, utf8_len().
package utf_pkg;

   localparam logic [1:0] UTF8    = 2'b00;
   localparam logic [1:0] UTF16LE = 2'b01;
   localparam logic [1:0] UTF16BE = 2'b10;

   localparam logic [31:0] CP_REPL = 32'h0000_FFFD;
   localparam logic [31:0] CP_MAX  = 32'h0010_FFFF;
   localparam logic [31:0] SURR_LO = 32'h0000_D800;
   localparam logic [31:0] SURR_HI = 32'h0000_DFFF;

   typedef enum logic {IDLE, EMIT} state_t;

   // Element [0] is the first byte on the wire.
   typedef logic [5:0][7:0] byte_vec_t;

   function automatic logic [2:0] utf8_len(input logic [31:0] c);
      if (c < 32'h0000_0080)      return 3'd1;
      else if (c < 32'h0000_0800) return 3'd2;
      else if (c < 32'h0001_0000) return 3'd3;
      else if (c < 32'h0020_0000) return 3'd4;
      else if (c < 32'h0400_0000) return 3'd5;
      else                        return 3'd6;
   endfunction

endpackage

// File: rtl/utf_stream_encoder_if.sv
// rtl/utf_stream_encoder_if.sv - code-point in / byte out handshake bundle
// Signals: mode, cp_valid/cp_ready/cp (code point stream), byte_valid/byte_ready/byte_data/byte_last
// (byte stream), err_invalid, err_count, busy (status). master = producer/sink side, slave = encoder.
interface utf_stream_encoder_if;
   logic [1:0]  mode;
   logic        cp_valid;
   logic        cp_ready;
   logic [31:0] cp;
   logic        byte_valid;
   logic        byte_ready;
   logic [7:0]  byte_data;
   logic        byte_last;
   logic        err_invalid;
   logic [15:0] err_count;
   logic        busy;

   modport master (
      output mode, cp_valid, cp, byte_ready,
      input  cp_ready, byte_valid, byte_data, byte_last, err_invalid, err_count, busy
   );

   modport slave (
      input  mode, cp_valid, cp, byte_ready,
      output cp_ready, byte_valid, byte_data, byte_last, err_invalid, err_count, busy
   );
endinterface

// File: rtl/utf_cp_encode.sv
// rtl/utf_cp_encode.sv - combinational code point to UTF-8 / UTF-16LE / UTF-16BE byte encoder
// Ports: cp (code point), mode (encoding), invalid (cp not encodable), len (byte count 1..6),
// bytes (encoded bytes, [0] first). Invalid input yields the U+FFFD encoding in the same mode.
module utf_cp_encode
   import utf_pkg::*;
#(
   parameter bit CHK_RANGE = 1'b1
) (
   input  logic [31:0] cp,
   input  logic [1:0]  mode,
   output logic        invalid,
   output logic [2:0]  len,
   output byte_vec_t   bytes
);

   logic        is16;
   logic [31:0] ecp;
   logic [19:0] cpp;
   logic [15:0] hs;
   logic [15:0] ls;

   always_comb begin
      is16    = (mode == UTF16LE) || (mode == UTF16BE);
      invalid = cp[31] || ((cp >= SURR_LO) && (cp <= SURR_HI)) ||
                ((cp > CP_MAX) && (CHK_RANGE || is16));
      // Encode the replacement instead; the top decides whether to drop it.
      ecp     = invalid ? CP_REPL : cp;
      // Subtract 0x10000 only on the plane bits so the full 20-bit offset survives.
      cpp     = {ecp[20:16] - 5'd1, ecp[15:0]};
      hs      = {6'b110110, cpp[19:10]};
      ls      = {6'b110111, cpp[9:0]};
      bytes   = '0;
      len     = 3'd1;

      if (is16) begin
         if (ecp < 32'h0001_0000) begin
            len = 3'd2;
            if (mode == UTF16LE) bytes[1:0] = {ecp[15:8], ecp[7:0]};
            else                 bytes[1:0] = {ecp[7:0], ecp[15:8]};
         end else begin
            len = 3'd4;
            if (mode == UTF16LE) bytes[3:0] = {ls[15:8], ls[7:0], hs[15:8], hs[7:0]};
            else                 bytes[3:0] = {ls[7:0], ls[15:8], hs[7:0], hs[15:8]};
         end
      end else begin
         len = utf8_len(ecp);
         case (len)
            3'd1: bytes[0] = {1'b0, ecp[6:0]};
            3'd2: bytes[1:0] = {{2'b10, ecp[5:0]}, {3'b110, ecp[10:6]}};
            3'd3: bytes[2:0] = {{2'b10, ecp[5:0]}, {2'b10, ecp[11:6]}, {4'b1110, ecp[15:12]}};
            3'd4: bytes[3:0] = {{2'b10, ecp[5:0]}, {2'b10, ecp[11:6]}, {2'b10, ecp[17:12]},
                                {5'b11110, ecp[20:18]}};
            3'd5: bytes[4:0] = {{2'b10, ecp[5:0]}, {2'b10, ecp[11:6]}, {2'b10, ecp[17:12]},
                                {2'b10, ecp[23:18]}, {6'b111110, ecp[25:24]}};
            default: bytes = {{2'b10, ecp[5:0]}, {2'b10, ecp[11:6]}, {2'b10, ecp[17:12]},
                              {2'b10, ecp[23:18]}, {2'b10, ecp[29:24]}, {7'b1111110, ecp[30]}};
         endcase
      end
   end

endmodule

// File: rtl/utf_stream_encoder.sv
// rtl/utf_stream_encoder.sv - streams one code point per handshake out as UTF-8/UTF-16 bytes
// Ports: clk (rising edge), rst (async, active-low), bus (slave side of utf_stream_encoder_if:
// code point stream in, byte stream out, error pulse/counter and busy status).
module utf_stream_encoder
   import utf_pkg::*;
#(
   parameter bit REPLACE_INVALID = 1'b1,
   parameter bit CHK_RANGE       = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   utf_stream_encoder_if.slave    bus
);

   state_t     state, state_nx;
   byte_vec_t  buf_q;
   logic [2:0] len_q;
   logic [2:0] idx_q;

   logic       enc_invalid;
   logic [2:0] enc_len;
   byte_vec_t  enc_bytes;

   logic       last;
   logic       accept;
   logic       drop;
   logic       xfer;

   utf_cp_encode #(.CHK_RANGE(CHK_RANGE)) u_encode (
      .cp      (bus.cp),
      .mode    (bus.mode),
      .invalid (enc_invalid),
      .len     (enc_len),
      .bytes   (enc_bytes)
   );

   always_comb begin
      last          = (state == EMIT) && (idx_q == len_q - 3'd1);
      xfer          = (state == EMIT) && bus.byte_ready;
      // Taking the next code point on the final byte's handshake keeps the output gap-free.
      bus.cp_ready  = rst && ((state == IDLE) || (xfer && last));
      accept        = bus.cp_valid && bus.cp_ready;
      drop          = enc_invalid && !REPLACE_INVALID;
      bus.byte_valid = (state == EMIT);
      bus.byte_data  = (state == EMIT) ? buf_q[idx_q] : 8'h00;
      bus.byte_last  = last;
      bus.busy       = (state == EMIT);

      state_nx = state;
      if (accept && !drop)  state_nx = EMIT;
      else if (xfer && last) state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         buf_q           <= '0;
         len_q           <= 3'd0;
         idx_q           <= 3'd0;
         bus.err_invalid <= 1'b0;
         bus.err_count   <= 16'h0000;
      end else begin
         state           <= state_nx;
         bus.err_invalid <= accept && enc_invalid;
         if (accept && enc_invalid && (bus.err_count != 16'hFFFF))
            bus.err_count <= bus.err_count + 16'd1;

         if (accept && !drop) begin
            buf_q <= enc_bytes;
            len_q <= enc_len;
            idx_q <= 3'd0;
         end else if (xfer && !last) begin
            idx_q <= idx_q + 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_utf_stream_encoder.sv
// tb/tb_utf_stream_encoder.sv - directed vector bench for utf_stream_encoder
// Two instances share stimulus: dut_a (replace, range-checked) and dut_b (drop, unchecked range).
module tb_utf_stream_encoder;
   import utf_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  mode = UTF8;
   logic        cp_valid = 1'b0;
   logic [31:0] cp = '0;
   logic        byte_ready = 1'b0;
   bit          sel = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   int cnt_a    = 0;
   int cnt_b    = 0;

   always #5 clk = ~clk;

   utf_stream_encoder_if if_a ();
   utf_stream_encoder_if if_b ();

   assign if_a.mode = mode;  assign if_a.cp_valid = cp_valid;
   assign if_a.cp = cp;      assign if_a.byte_ready = byte_ready;
   assign if_b.mode = mode;  assign if_b.cp_valid = cp_valid;
   assign if_b.cp = cp;      assign if_b.byte_ready = byte_ready;

   utf_stream_encoder #(.REPLACE_INVALID(1'b1), .CHK_RANGE(1'b1)) dut_a (
      .clk(clk), .rst(rst), .bus(if_a));
   utf_stream_encoder #(.REPLACE_INVALID(1'b0), .CHK_RANGE(1'b0)) dut_b (
      .clk(clk), .rst(rst), .bus(if_b));

   logic        o_bv, o_bl, o_crdy, o_err, o_busy;
   logic [7:0]  o_bd;
   logic [15:0] o_cnt;
   assign o_bv   = sel ? if_b.byte_valid  : if_a.byte_valid;
   assign o_bl   = sel ? if_b.byte_last   : if_a.byte_last;
   assign o_bd   = sel ? if_b.byte_data   : if_a.byte_data;
   assign o_crdy = sel ? if_b.cp_ready    : if_a.cp_ready;
   assign o_err  = sel ? if_b.err_invalid : if_a.err_invalid;
   assign o_busy = sel ? if_b.busy        : if_a.busy;
   assign o_cnt  = sel ? if_b.err_count   : if_a.err_count;

   typedef struct {
      bit          sel;
      logic [1:0]  mode;
      logic [31:0] cp;
      int          n;
      logic [47:0] b;      // expected bytes, first byte in [47:40]
      bit          inv_a;
      bit          inv_b;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input bit s, input logic [1:0] m, input logic [31:0] c, input int n,
                      input logic [47:0] b, input bit ia, input bit ib);
      vec_t v;
      v.sel = s; v.mode = m; v.cp = c; v.n = n; v.b = b; v.inv_a = ia; v.inv_b = ib;
      vecs.push_back(v);
   endtask

   task automatic run_vec(input int i, input vec_t v);
      int got;
      bit inv;
      inv = v.sel ? v.inv_b : v.inv_a;
      @(posedge clk); #1;
      sel = v.sel; mode = v.mode; cp = v.cp; cp_valid = 1'b1; byte_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d cp_ready idle", i), o_crdy, 1);
      @(posedge clk); #1;
      cp_valid = 1'b0;
      mode = ~v.mode;                 // must not affect the character in flight
      cnt_a += int'(v.inv_a);
      cnt_b += int'(v.inv_b);
      got = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 0) chk($sformatf("v%0d err_invalid", i), o_err, inv);
         if (k == 1) chk($sformatf("v%0d err_invalid pulse end", i), o_err, 0);
         if (o_bv) begin
            if (got < v.n) begin
               chk($sformatf("v%0d byte%0d", i, got), o_bd, v.b[47 - 8*got -: 8]);
               chk($sformatf("v%0d last%0d", i, got), o_bl, (got == v.n - 1));
            end
            got++;
         end
      end
      chk($sformatf("v%0d byte count", i), got, v.n);
      chk($sformatf("v%0d err_count", i), o_cnt, v.sel ? cnt_b : cnt_a);
      chk($sformatf("v%0d busy after", i), o_busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] seq [4];
      bit taken;

      // reset state
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = bit'(s);
         #0;
         chk($sformatf("rst cp_ready %0d", s), o_crdy, 0);
         chk($sformatf("rst byte_valid %0d", s), o_bv, 0);
         chk($sformatf("rst byte_data %0d", s), o_bd, 0);
         chk($sformatf("rst err_count %0d", s), o_cnt, 0);
         chk($sformatf("rst busy %0d", s), o_busy, 0);
      end
      @(posedge clk); #1 rst = 1'b1;
      sel = 1'b0;
      @(negedge clk);
      chk("idle no valid", o_bv, 0);

      add(0, UTF8,    32'h41,        1, 48'h41_0000000000, 0, 0);
      add(0, UTF8,    32'h1F600,     4, 48'hF09F9880_0000, 0, 0);
      add(0, UTF16LE, 32'h1F600,     4, 48'h3DD800DE_0000, 0, 0);
      add(0, UTF16BE, 32'h1F600,     4, 48'hD83DDE00_0000, 0, 0);
      add(0, UTF8,    32'hD800,      3, 48'hEFBFBD_000000, 1, 1);
      add(1, UTF8,    32'hD800,      0, 48'h0,             1, 1);
      add(1, UTF8,    32'h110000,    4, 48'hF4908080_0000, 1, 0);
      add(0, UTF16LE, 32'h110000,    2, 48'hFDFF_00000000, 1, 1);
      add(0, UTF16BE, 32'h20AC,      2, 48'h20AC_00000000, 0, 0);
      add(0, UTF16LE, 32'h20AC,      2, 48'hAC20_00000000, 0, 0);
      add(0, UTF8,    32'h7FF,       2, 48'hDFBF_00000000, 0, 0);
      add(0, UTF8,    32'h80,        2, 48'hC280_00000000, 0, 0);
      add(1, UTF8,    32'h7FFFFFFF,  6, 48'hFDBFBFBFBFBF,  1, 0);
      add(1, UTF8,    32'h4000000,   6, 48'hFC8480808080,  1, 0);
      add(1, UTF8,    32'h200000,    5, 48'hF888808080_00, 1, 0);
      add(0, UTF8,    32'h80000000,  3, 48'hEFBFBD_000000, 1, 1);
      add(0, UTF8,    32'h10FFFF,    4, 48'hF48FBFBF_0000, 0, 0);
      add(0, UTF16LE, 32'h10FFFF,    4, 48'hFFDBFFDF_0000, 0, 0);
      add(0, UTF8,    32'hD7FF,      3, 48'hED9FBF_000000, 0, 0);
      add(0, UTF8,    32'hE000,      3, 48'hEE8080_000000, 0, 0);
      add(0, UTF16BE, 32'hDFFF,      2, 48'hFFFD_00000000, 1, 1);
      add(1, UTF16BE, 32'h10FFFF,    4, 48'hDBFFDFFF_0000, 0, 0);

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // back-to-back 0x20AC then 0x41 with no gap
      seq[0] = 8'hE2; seq[1] = 8'h82; seq[2] = 8'hAC; seq[3] = 8'h41;
      @(posedge clk); #1;
      sel = 1'b0; mode = UTF8; cp = 32'h20AC; cp_valid = 1'b1; byte_ready = 1'b1;
      @(posedge clk); #1 cp = 32'h41;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("b2b valid%0d", k), o_bv, 1);
         chk($sformatf("b2b byte%0d", k), o_bd, seq[k]);
         if (k == 2) chk("b2b cp_ready on last", o_crdy, 1);
         taken = cp_valid && o_crdy;
         @(posedge clk); #1;
         if (taken) cp_valid = 1'b0;
      end
      @(negedge clk);
      chk("b2b idle after", o_bv, 0);

      // backpressure on the second byte of 0x20AC
      @(posedge clk); #1;
      cp = 32'h20AC; cp_valid = 1'b1; byte_ready = 1'b1;
      @(posedge clk); #1 cp = 32'h41;
      @(negedge clk);
      chk("bp byte0", o_bd, 8'hE2);
      @(posedge clk); #1 byte_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("bp hold data%0d", k), o_bd, 8'h82);
         chk($sformatf("bp hold valid%0d", k), o_bv, 1);
         chk($sformatf("bp hold cp_ready%0d", k), o_crdy, 0);
         @(posedge clk);
      end
      #1 byte_ready = 1'b1;
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("bp resume byte%0d", k), o_bd, seq[k]);
         chk($sformatf("bp resume last%0d", k), o_bl, (k == 2 || k == 3));
         taken = cp_valid && o_crdy;
         @(posedge clk); #1;
         if (taken) cp_valid = 1'b0;
      end

      // async reset mid-character on dut_b
      @(posedge clk); #1;
      sel = 1'b1; mode = UTF8; cp = 32'h110000; cp_valid = 1'b1;
      @(posedge clk); #1 cp_valid = 1'b0;
      @(negedge clk);
      chk("rst-mid byte0", o_bd, 8'hF4);
      chk("rst-mid err_count before", o_cnt, cnt_b);
      @(negedge clk);
      chk("rst-mid byte1", o_bd, 8'h90);
      #2 rst = 1'b0;
      #1;
      chk("rst-mid byte_valid", o_bv, 0);
      chk("rst-mid busy", o_busy, 0);
      chk("rst-mid err_count", o_cnt, 0);
      chk("rst-mid cp_ready", o_crdy, 0);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      chk("rst-mid no replay", o_bv, 0);
      chk("rst-mid cp_ready after", o_crdy, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
